dsp_mem_arbiter: RTL and testbench
==================================

Name: dsp_mem_arbiter

Overview:
- Shares the single-port data SRAM bank II between two requesters: the DSP core memory stage (core port) and an external sample/host loader (ext port).
- The core has default priority. A starvation counter forces ext ownership for a bounded burst, and the core is stalled through core_stall while ext owns the bank.
- The block sits between the DSP mem stage and the bank II SRAM pins. core_stall feeds the core clock-gating logic.

Parameters:
ADDR_W, 12, SRAM address width; equals SRAM_ADDR_LEN
DATA_W, 16, data word width; equals REG_WORD_LEN
MAX_WAIT, 4, number of consecutive cycles ext may be denied before forced ownership (range 1..15)
EXT_BURST, 4, maximum consecutive ext beats per forced ownership (range 1..15)

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
core_req  in  1  core access this cycle
core_we  in  1  core write (1) / read (0)
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core write data
core_rdata  out  DATA_W  core read data, valid the cycle after the core access is performed
core_stall  out  1  combinational; core_req high and bank not granted to core this cycle
ext_req  in  1  ext request; held high until ext_gnt
ext_we  in  1  ext write/read
ext_addr  in  ADDR_W  ext address
ext_wdata  in  DATA_W  ext write data
ext_gnt  out  1  combinational; ext access performed this cycle
ext_rdata  out  DATA_W  ext read data
ext_rvalid  out  1  registered; ext_rdata valid this cycle
sram_addr  out  ADDR_W  to SRAM
sram_wdata  out  DATA_W  to SRAM
sram_we  out  1  to SRAM
sram_rdata  in  DATA_W  SRAM synchronous read data, 1-cycle latency

Behaviour:
- Reset (rst=0, async):
  - state=S_CORE; wait_cnt=0; beat_cnt=0; owner_q=NONE.
  - core_rdata=0; ext_rdata=0; ext_rvalid=0.
  - Outputs are driven with req=0: sram_we=0, ext_gnt=0, core_stall=0.
  - Reset mid-burst abandons the burst. An in-flight read produces no rvalid.
- Grant (combinational from state and requests):
  - S_CORE: core granted if core_req. Ext granted only if ext_req and !core_req (opportunistic; no state change).
  - S_EXT: ext granted if ext_req. Core is never granted, so core_stall=core_req.
- SRAM mux:
  - Granted requester drives sram_addr, sram_wdata and sram_we.
  - With no grant: sram_we=0 and sram_addr holds its last value (registered hold not required; drive core_addr).
- Starvation (S_CORE only):
  - wait_cnt increments each cycle ext_req=1 and ext not granted. It clears when ext is granted or ext_req=0.
  - When wait_cnt==MAX_WAIT-1 and ext is again denied: next state S_EXT, beat_cnt=0, wait_cnt=0.
- S_EXT:
  - beat_cnt increments per ext grant.
  - Return to S_CORE at the next edge when ext_req=0, or when a grant occurs with beat_cnt==EXT_BURST-1.
- Read return:
  - owner_q registers {CORE, EXT, NONE} for the read performed this cycle. Writes set NONE.
  - Next cycle, if owner_q==CORE: core_rdata<=sram_rdata is captured combinationally-through. core_rdata = owner_q==CORE ? sram_rdata : held register.
  - If owner_q==EXT: ext_rdata=sram_rdata and ext_rvalid=1 for exactly one cycle.
  - Held registers update on their own owner's return only.
- Simultaneous events:
  - Ext read immediately followed by a core write to the same address: ordering is by grant order, and the read returns the old data.
  - Both requests with MAX_WAIT reached: the forced transition wins from the next cycle. The current cycle still grants the core.
- Throughput: one access per cycle total. Latency: write 0 cycles (performed in grant cycle); read data 1 cycle after grant.
- Counter widths: 4 bits; parameter range enforced by an elaboration check.

Decomposition:
- Add to definitions.v: ARB_S_CORE/ARB_S_EXT state encodings, OWNER_NONE/CORE/EXT encodings, ARB_CNT_LEN=4.
- One natural sub-module: arb_sat_counter (clear/increment/terminal-count flag, async active-low reset), instantiated for wait_cnt and beat_cnt.
- The grant mux and read-return steering stay in dsp_mem_arbiter.

Test Plan:
- Core-only traffic: core write 0x010<=0xBEEF, then core read 0x010 → core_stall=0 throughout; core_rdata=0xBEEF one cycle after the read grant.
- Ext with core idle: ext read 0x020 (preloaded 0x1234) → ext_gnt same cycle; ext_rvalid=1 with ext_rdata=0x1234 next cycle for exactly 1 cycle.
- Starvation: core_req held high, ext_req high from cycle 0, MAX_WAIT=4 → ext denied in cycles 0-3, state S_EXT from cycle 4; ext_gnt=1 and core_stall=1 in cycles 4-7 (EXT_BURST=4); core regranted in cycle 8.
- Early burst end: in S_EXT, ext_req drops after 2 beats → return to S_CORE next edge; core_stall falls; wait_cnt=0.
- Reset mid-operation: assert rst=0 during the S_EXT beat after an ext read grant → ext_rvalid stays 0; all outputs are at reset values asynchronously; after release, state=S_CORE.
- Ordering hazard: ext read 0x030 (old 0x0001) granted, then core write 0x030<=0x0002 next cycle → ext_rdata=0x0001; a subsequent core read returns 0x0002.

Source files
------------

// File: rtl/dsp_mem_arbiter_pkg.sv
// rtl/dsp_mem_arbiter_pkg.sv - shared encodings for the bank II memory arbiter
package dsp_mem_arbiter_pkg;

  localparam int ARB_CNT_LEN = 4;

  typedef enum logic {
    ARB_S_CORE = 1'b0,
    ARB_S_EXT  = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CORE = 2'd1,
    OWNER_EXT  = 2'd2
  } owner_e;

endpackage

// File: rtl/dsp_mem_arbiter_arb_sat_counter.sv
// rtl/dsp_mem_arbiter_arb_sat_counter.sv - saturating counter with clear and terminal-count flag
module arb_sat_counter #(
  parameter int W  = 4,
  parameter int TC = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear has priority; increment stops at all-ones so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC[W-1:0]);

endmodule

// File: rtl/dsp_mem_arbiter.sv
// rtl/dsp_mem_arbiter.sv - core-priority arbiter for the single-port bank II SRAM
module dsp_mem_arbiter
  import dsp_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int MAX_WAIT  = 4,
  parameter int EXT_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  input  logic [DATA_W-1:0] sram_rdata
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("dsp_mem_arbiter: MAX_WAIT out of range 1..15");
  end
  if (EXT_BURST < 1 || EXT_BURST > 15) begin : g_bad_ext_burst
    $error("dsp_mem_arbiter: EXT_BURST out of range 1..15");
  end

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] core_rdata_q;
  logic [DATA_W-1:0] ext_rdata_q;
  logic              ext_rvalid_q;
  logic              core_gnt;
  logic              wait_inc, wait_clr, wait_tc;
  logic              beat_inc, beat_clr, beat_tc;

  arb_sat_counter #(.W(ARB_CNT_LEN), .TC(MAX_WAIT - 1)) u_wait_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (wait_clr),
    .inc_i  (wait_inc),
    .tc_o   (wait_tc)
  );

  arb_sat_counter #(.W(ARB_CNT_LEN), .TC(EXT_BURST - 1)) u_beat_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (beat_clr),
    .inc_i  (beat_inc),
    .tc_o   (beat_tc)
  );

  // Grants and SRAM pin mux; ext only slips in during S_CORE when the core is idle.
  always_comb begin
    core_gnt   = (state_q == ARB_S_CORE) && core_req;
    ext_gnt    = ext_req && ((state_q == ARB_S_EXT) || !core_req);
    core_stall = core_req && !core_gnt;
    sram_addr  = core_addr;
    sram_wdata = core_wdata;
    sram_we    = 1'b0;
    owner_d    = OWNER_NONE;
    if (core_gnt) begin
      sram_we = core_we;
      owner_d = core_we ? OWNER_NONE : OWNER_CORE;
    end else if (ext_gnt) begin
      sram_addr  = ext_addr;
      sram_wdata = ext_wdata;
      sram_we    = ext_we;
      owner_d    = ext_we ? OWNER_NONE : OWNER_EXT;
    end
  end

  // Ownership FSM: starvation forces ext ownership, bounded by the burst limit.
  always_comb begin
    state_d  = state_q;
    wait_inc = 1'b0;
    wait_clr = 1'b0;
    beat_inc = 1'b0;
    beat_clr = 1'b0;
    case (state_q)
      ARB_S_CORE: begin
        beat_clr = 1'b1;
        if (ext_req && !ext_gnt) begin
          if (wait_tc) begin
            state_d  = ARB_S_EXT;
            wait_clr = 1'b1;
          end else begin
            wait_inc = 1'b1;
          end
        end else begin
          wait_clr = 1'b1;
        end
      end
      ARB_S_EXT: begin
        wait_clr = 1'b1;
        beat_inc = ext_gnt;
        if (!ext_req || (ext_gnt && beat_tc)) begin
          state_d  = ARB_S_CORE;
          beat_clr = 1'b1;
        end
      end
      default: state_d = ARB_S_CORE;
    endcase
  end

  // State, read-owner tag and per-owner held read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_S_CORE;
      owner_q      <= OWNER_NONE;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
      ext_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ext_rvalid_q <= (owner_d == OWNER_EXT);
      if (owner_q == OWNER_CORE) core_rdata_q <= sram_rdata;
      if (owner_q == OWNER_EXT)  ext_rdata_q  <= sram_rdata;
    end
  end

  assign core_rdata = (owner_q == OWNER_CORE) ? sram_rdata : core_rdata_q;
  assign ext_rdata  = (owner_q == OWNER_EXT)  ? sram_rdata : ext_rdata_q;
  assign ext_rvalid = ext_rvalid_q;

endmodule

// File: tb/tb_dsp_mem_arbiter.sv
// tb/tb_dsp_mem_arbiter.sv - directed self-checking bench for dsp_mem_arbiter
module tb_dsp_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        core_req, core_we;
  logic [11:0] core_addr;
  logic [15:0] core_wdata;
  logic [15:0] core_rdata;
  logic        core_stall;
  logic        ext_req, ext_we;
  logic [11:0] ext_addr;
  logic [15:0] ext_wdata;
  logic        ext_gnt;
  logic [15:0] ext_rdata;
  logic        ext_rvalid;
  logic [11:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_we;
  logic [15:0] sram_rdata;

  logic [15:0] mem [0:4095];
  int tests = 0;
  int fails = 0;

  dsp_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .MAX_WAIT(4), .EXT_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rdata  (ext_rdata),
    .ext_rvalid (ext_rvalid),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_we    (sram_we),
    .sram_rdata (sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ext_req = 1'b0;  ext_we = 1'b0;  ext_addr = '0;  ext_wdata = '0;
    #2;
    chk("rst_core_rdata", core_rdata, 16'h0000);
    chk("rst_ext_rdata", ext_rdata, 16'h0000);
    chk("rst_ext_rvalid", ext_rvalid, 1'b0);
    chk("rst_sram_we", sram_we, 1'b0);
    chk("rst_ext_gnt", ext_gnt, 1'b0);
    chk("rst_core_stall", core_stall, 1'b0);
    #10 rst = 1'b1;
    tick();

    // preload through the core port
    core_req = 1'b1; core_we = 1'b1; core_addr = 12'h020; core_wdata = 16'h1234;
    tick();
    core_addr = 12'h030; core_wdata = 16'h0001;
    tick();

    // core-only write then read
    core_addr = 12'h010; core_wdata = 16'hBEEF;
    #1;
    chk("t1_wr_stall", core_stall, 1'b0);
    chk("t1_wr_sram_we", sram_we, 1'b1);
    chk("t1_wr_sram_addr", sram_addr, 12'h010);
    tick();
    core_we = 1'b0;
    #1;
    chk("t1_rd_stall", core_stall, 1'b0);
    chk("t1_rd_sram_we", sram_we, 1'b0);
    tick();
    core_req = 1'b0;
    #1;
    chk("t1_core_rdata", core_rdata, 16'hBEEF);

    // ext read with core idle
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'h020;
    #1;
    chk("t2_ext_gnt", ext_gnt, 1'b1);
    chk("t2_sram_addr", sram_addr, 12'h020);
    tick();
    ext_req = 1'b0;
    #1;
    chk("t2_rvalid", ext_rvalid, 1'b1);
    chk("t2_ext_rdata", ext_rdata, 16'h1234);
    chk("t2_core_rdata_held", core_rdata, 16'hBEEF);
    tick();
    #1;
    chk("t2_rvalid_one_cycle", ext_rvalid, 1'b0);
    chk("t2_ext_rdata_held", ext_rdata, 16'h1234);

    // starvation: denied 0-3, forced 4-7, core back in 8
    core_req = 1'b1; core_we = 1'b0; core_addr = 12'h010;
    ext_req = 1'b1;  ext_we = 1'b0;  ext_addr = 12'h020;
    for (int c = 0; c < 9; c++) begin
      #1;
      chk($sformatf("t3_ext_gnt_c%0d", c), ext_gnt, (c >= 4 && c <= 7) ? 1'b1 : 1'b0);
      chk($sformatf("t3_stall_c%0d", c), core_stall, (c >= 4 && c <= 7) ? 1'b1 : 1'b0);
      tick();
    end
    core_req = 1'b0; ext_req = 1'b0;
    tick();

    // early burst end after two beats
    core_req = 1'b1; ext_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("t4_ext_gnt_c%0d", c), ext_gnt, (c >= 4) ? 1'b1 : 1'b0);
      tick();
    end
    ext_req = 1'b0;
    #1;
    chk("t4_stall_ext_idle", core_stall, 1'b1);
    chk("t4_gnt_ext_idle", ext_gnt, 1'b0);
    tick();
    #1;
    chk("t4_stall_back", core_stall, 1'b0);
    tick();

    // wait count restarts from zero; reset lands in the forced ext read beat
    ext_req = 1'b1; ext_addr = 12'h020;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("t5_denied_c%0d", c), ext_gnt, 1'b0);
      tick();
    end
    #1;
    chk("t5_forced_gnt", ext_gnt, 1'b1);
    rst = 1'b0; core_req = 1'b0; ext_req = 1'b0;
    #1;
    chk("t5_rst_rvalid", ext_rvalid, 1'b0);
    chk("t5_rst_sram_we", sram_we, 1'b0);
    chk("t5_rst_ext_gnt", ext_gnt, 1'b0);
    chk("t5_rst_stall", core_stall, 1'b0);
    chk("t5_rst_core_rdata", core_rdata, 16'h0000);
    chk("t5_rst_ext_rdata", ext_rdata, 16'h0000);
    tick();
    #1;
    chk("t5_no_rvalid", ext_rvalid, 1'b0);
    rst = 1'b1;
    tick();
    core_req = 1'b1; ext_req = 1'b1;
    #1;
    chk("t5_core_state_stall", core_stall, 1'b0);
    chk("t5_core_state_gnt", ext_gnt, 1'b0);
    tick();
    core_req = 1'b0; ext_req = 1'b0;
    tick();

    // ordering hazard: ext read then core write to the same word
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'h030;
    #1;
    chk("t6_ext_gnt", ext_gnt, 1'b1);
    tick();
    ext_req = 1'b0;
    core_req = 1'b1; core_we = 1'b1; core_addr = 12'h030; core_wdata = 16'h0002;
    #1;
    chk("t6_wr_stall", core_stall, 1'b0);
    chk("t6_rvalid", ext_rvalid, 1'b1);
    chk("t6_old_data", ext_rdata, 16'h0001);
    tick();
    core_we = 1'b0;
    tick();
    core_req = 1'b0;
    #1;
    chk("t6_new_data", core_rdata, 16'h0002);
    chk("t6_no_rvalid", ext_rvalid, 1'b0);
    chk("t6_ext_held", ext_rdata, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
